// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, frame geometry,
// common keyboard command codes and small helpers used by the host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE
    } state_e;

    // Start bit, eight data bits, parity and stop.
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Bits shifted after the start bit, LSB first: {stop, odd parity, data}.
    function automatic logic [PS2_FRAME_BITS-2:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 line: 2-flop synchronizer, stability filter and a
// single-cycle strobe on each filtered falling edge. Idle (released) level is 1.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] stable_cnt;

    // NOTE: every register here is updated with nonblocking assignments so all
    // flops sample pre-edge values; blocking writes would turn the sync chain into a wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            stable_cnt <= '0;
            level      <= 1'b1;
            fall       <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                // Line has disagreed with the filtered value long enough: accept it.
                level      <= sync[1];
                stable_cnt <= '0;
                fall       <= level;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then
// shifts one command byte on device clock falls and checks the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC      = 5000,
    parameter int REQ_TIMEOUT_CYC  = 750000,
    parameter int XFER_TIMEOUT_CYC = 100000,
    parameter int FILTER_LEN       = 8
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_timeout
);

    localparam int MAX_CYC = max3(INHIBIT_CYC, REQ_TIMEOUT_CYC, XFER_TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e                      state;
    logic [CNT_W-1:0]            cnt;
    logic [3:0]                  bit_cnt;
    logic [PS2_FRAME_BITS-2:0]   frame;
    logic                        ack_bad;
    logic                        clk_level;
    logic                        clk_fall;
    logic                        dat_level;
    logic                        dat_fall_unused;
    logic                        xfer_expired;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .raw   (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .raw   (ps2_dat_i),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    assign xfer_expired = (cnt == CNT_W'(XFER_TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            tx_timeout <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            ack_bad    <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            tx_timeout <= 1'b0;
            // One saturating timer serves inhibit, request and transfer phases.
            if (state != IDLE && cnt != '1) cnt <= cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        frame      <= make_frame(tx_data);
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        ack_bad    <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b1;
                        cnt        <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (cnt == CNT_W'(REQ_TIMEOUT_CYC - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_timeout <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (clk_fall) begin
                        ps2_dat_oe <= ~frame[0];
                        bit_cnt    <= 4'd1;
                        cnt        <= '0;
                        state      <= DATA;
                    end
                end
                DATA, ACK, WAIT_IDLE: begin
                    if (xfer_expired) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_timeout <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (state == DATA) begin
                        if (clk_fall) begin
                            if (bit_cnt <= 4'd9) begin
                                ps2_dat_oe <= ~frame[bit_cnt];
                                bit_cnt    <= bit_cnt + 1'b1;
                            end else begin
                                // 11th fall: the device must be holding data low.
                                ack_bad    <= dat_level;
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        tx_err <= ack_bad;
                        state  <= WAIT_IDLE;
                    end else if (clk_level && dat_level) begin
                        tx_done <= ~ack_bad;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on an open-collector bus, a
// scoreboard of expected transfer outcomes and a monitor that checks each pulse.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 50;
    localparam int REQ_TO  = 200;
    localparam int XFER_TO = 600;
    localparam int HALF    = 20;

    typedef enum int {R_DONE, R_ERR, R_TIMEOUT, R_NONE} res_e;
    typedef enum int {M_ACK, M_NACK, M_SILENT, M_STOP4, M_GLITCH, M_RESET} dev_e;
    typedef struct {
        res_e       res;
        logic [9:0] bits;
        bit         chk_bits;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_err, tx_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       glitch = 1'b0;
    logic       ps2_clk_i, ps2_dat_i;
    logic [9:0] dev_bits = '0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_got;

    // Open-collector bus: low if either side pulls; glitch flips the clock pin.
    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low) ^ glitch;
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYC      (INHIBIT),
        .REQ_TIMEOUT_CYC  (REQ_TO),
        .XFER_TIMEOUT_CYC (XFER_TO),
        .FILTER_LEN       (2)
    ) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame from the protocol rules: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int  ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Monitor: every completion pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (tx_done || tx_err || tx_timeout)) begin
            check("single_pulse", 32'(tx_done) + 32'(tx_err) + 32'(tx_timeout), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'b0, tx_done, tx_err, tx_timeout}, 32'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_got = tx_done ? int'(R_DONE) : (tx_err ? int'(R_ERR) : int'(R_TIMEOUT));
                check("result_kind", mon_got, int'(mon_e.res));
                if (mon_e.chk_bits) check("frame_bits", {22'b0, dev_bits}, {22'b0, mon_e.bits});
                if (mon_e.at >= 0) check("timeout_cycle", cyc, mon_e.at);
                check("bus_released_at_pulse", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input res_e res, input bit chk, input int at_off);
        exp_t e;
        int   p;
        int   n = 0;
        @(negedge clk);
        while (!tx_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("tx_ready_before_send", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        p        = cyc + 1;
        if (res != R_NONE) begin
            e.res      = res;
            e.bits     = model_frame(d);
            e.chk_bits = chk;
            e.at       = (at_off >= 0) ? p + at_off : -1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = $urandom;
    endtask

    // Behavioural keyboard: waits out the inhibit, clocks the frame, then acks or not.
    task automatic device(input dev_e mode);
        int n = 0;
        bit dat_early = 1'b0;
        while (ps2_clk_oe && n < 1000) begin
            if (ps2_dat_oe) dat_early = 1'b1;
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INHIBIT);
        check("dat_low_during_inhibit", dat_early, 0);
        check("start_bit_on_release", ps2_dat_oe, 1);
        if (mode == M_SILENT) return;
        repeat (30) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            if (mode == M_RESET && i == 5) begin
                repeat (10) @(negedge clk);
                check("pre_reset_busy_dat", {30'b0, busy, ps2_dat_oe}, 32'd3);
                rst_n = 1'b0;
                #1;
                check("reset_releases_bus", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
                check("reset_ready_busy", {30'b0, tx_ready, busy}, 32'd2);
                dev_clk_low = 1'b0;
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            dev_bits[i] = ps2_dat_i;
            if (mode == M_GLITCH && i == 5) begin
                repeat (10) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (mode == M_STOP4 && i == 3) return;
        end
        if (mode != M_NACK) dev_dat_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(tx_ready && !busy) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check(name, {28'b0, ps2_clk_oe, ps2_dat_oe, tx_ready, busy}, 32'b0010);
    endtask

    initial begin
        logic [7:0] d;
        bit         ack;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {25'b0, tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_err, tx_timeout},
              32'b1000000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {30'b0, tx_ready, busy}, 32'd2);

        send(CMD_SET_LEDS, R_DONE, 1'b1, -1);
        device(M_ACK);
        wait_idle("idle_after_ack");

        send(8'h01, R_ERR, 1'b1, -1);
        device(M_NACK);
        wait_idle("idle_after_nack");

        send(CMD_RESET, R_TIMEOUT, 1'b0, INHIBIT + REQ_TO);
        device(M_SILENT);
        wait_idle("idle_after_req_timeout");

        send(8'h5A, R_TIMEOUT, 1'b0, -1);
        device(M_STOP4);
        wait_idle("idle_after_xfer_timeout");

        send(CMD_SET_LEDS, R_DONE, 1'b1, -1);
        device(M_ACK);
        wait_idle("idle_after_recovery");

        send(8'h00, R_NONE, 1'b0, -1);
        device(M_RESET);
        repeat (5) @(negedge clk);
        check("ready_after_reset_release", {30'b0, tx_ready, busy}, 32'd2);

        send(8'hA5, R_DONE, 1'b1, -1);
        device(M_GLITCH);
        wait_idle("idle_after_glitch");

        for (int k = 0; k < 4; k++) begin
            d   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            send(d, ack ? R_DONE : R_ERR, 1'b1, -1);
            device(ack ? M_ACK : M_NACK);
            wait_idle("idle_after_random");
        end

        repeat (20) @(negedge clk);
        check("pending_responses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
